regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised, fully synchronous general-purpose register file for the MIPS datapath; successor to the fixed 32x32 two-read-port file.
- Configurable width, depth and number of read ports; one write port.
- Built-in post-reset clear sequencer zeroes every entry; a `ready` flag gates the decode stage.
- Registered reads with optional same-cycle write-to-read bypass; optional hardwired zero register.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, >=2.
- SEL_W, $clog2(DEPTH), address width; derived, not overridden.
- READ_PORTS, 2, number of independent read ports, 1..4.
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- we  input  1  write enable.
- waddr  input  SEL_W  write address.
- wdata  input  WIDTH  write data.
- raddr  input  READ_PORTS*SEL_W  packed read addresses; port i = bits [i*SEL_W +: SEL_W].
- rdata  output  READ_PORTS*WIDTH  packed registered read data; port i = bits [i*WIDTH +: WIDTH].
- ready  output  1  high once clear sequence is done; accesses are honoured only while high.

Behaviour:
- Reset: any rising clk with rst_n=0 has these effects:
  - state <= CLEAR, clr_idx <= 0, rdata <= 0, ready <= 0.
  - Array contents untouched that cycle.
  - Reset asserted mid-CLEAR restarts the clear from index 0.
  - Reset asserted in READY returns to CLEAR.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle with rst_n=1: mem[clr_idx] <= 0; clr_idx <= clr_idx+1.
  - When clr_idx == DEPTH-1, write the final zero and go to READY. The clear takes exactly DEPTH cycles after reset deasserts.
  - we is ignored; rdata is held at 0; ready=0.
- READY:
  - ready=1 (registered; first high on the edge that leaves CLEAR). The state is never left except by reset.
- Write:
  - In READY, if we=1 then mem[waddr] <= wdata at the rising edge.
  - If ZERO_REG=1 and waddr==0, the write is dropped.
- Read:
  - In READY, at each rising edge rdata[i] <= mem[raddr[i]]. Latency is 1 cycle.
  - The address is sampled at the edge; output is stable until the next edge.
  - If ZERO_REG=1 and raddr[i]==0, rdata[i] <= 0 regardless of array contents.
- Read-during-write to the same address in one cycle, without the bypass feature:
  - rdata returns the OLD value.
  - The new value is visible to a read issued the following cycle.
- Multiple read ports addressing the same entry all return the identical value.
- Out-of-range addresses cannot occur (DEPTH is a power of two).
- No X on rdata after reset: all reads return 0 until written.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, when we=1 and raddr[i]==waddr (and, if ZERO_REG=1, waddr!=0), rdata[i] <= wdata in the same edge (write-first). A zero-register read still returns 0.
- Not defined: read-first behaviour as above; no bypass mux is generated.

Test Plan:
- Reset and clear: rst_n=0 for 3 cycles, then 1 -> ready=0 for exactly 32 cycles, ready=1 on the 32nd edge after deassert; reading every address 0..31 returns 0x00000000.
- Reset during clear: deassert, wait 10 cycles, assert rst_n=0 for 1 cycle, release -> ready rises 32 cycles after the second release; entries 10..31 read 0.
- Basic write/read: write 0xDEADBEEF to r5, next cycle raddr0=5, raddr1=5 -> both ports show 0xDEADBEEF one cycle later.
- Zero register: write 0x12345678 to r0 -> a read of r0 returns 0; with ZERO_REG=0, the same read returns 0x12345678.
- Read-during-write: r7=0x11111111; same cycle we=1, waddr=7, wdata=0x22222222, raddr0=7 -> rdata0=0x11111111 without the macro, 0x22222222 with REGFILE_BYPASS_EN; the following read returns 0x22222222 in both builds.
- Access gating: during CLEAR drive we=1, waddr=3, wdata=0xFFFFFFFF -> after ready, r3 reads 0; rdata stays 0 throughout CLEAR.

Source files
------------

// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with post-reset clear sequencer and registered reads.
// Optional build macro REGFILE_BYPASS_EN enables write-first forwarding of same-edge writes to reads.
module regfile_multiport #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int SEL_W      = $clog2(DEPTH),
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [SEL_W-1:0]              waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [READ_PORTS*SEL_W-1:0]   raddr,
  output logic [READ_PORTS*WIDTH-1:0]   rdata,
  output logic                          ready
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

  state_e                        state_q, state_d;
  logic [SEL_W-1:0]              clr_idx_q, clr_idx_d;
  logic                          ready_q, ready_d;
  logic [READ_PORTS*WIDTH-1:0]   rdata_q, rdata_d;
  logic [WIDTH-1:0]              mem_q [DEPTH];

  logic                          mem_we;
  logic [SEL_W-1:0]              mem_waddr;
  logic [WIDTH-1:0]              mem_wdata;
  logic                          wr_ok;
  logic [SEL_W-1:0]              rd_addr;
  logic [WIDTH-1:0]              rd_val;

  // Next-state, array write port and per-port read data selection
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = 1'b0;
    rdata_d   = '0;
    mem_we    = 1'b0;
    mem_waddr = clr_idx_q;
    mem_wdata = '0;
    rd_addr   = '0;
    rd_val    = '0;
    wr_ok     = we && !((ZERO_REG != 0) && (waddr == '0));

    if (!rst_n) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_idx_q;
          if (clr_idx_q == LAST_IDX) begin
            state_d   = READY;
            ready_d   = 1'b1;
            clr_idx_d = '0;
          end else begin
            clr_idx_d = clr_idx_q + SEL_W'(1);
          end
        end
        READY: begin
          ready_d = 1'b1;
          if (wr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = waddr;
            mem_wdata = wdata;
          end else begin
            mem_we    = 1'b0;
          end
          for (int i = 0; i < READ_PORTS; i++) begin
            rd_addr = raddr[i*SEL_W +: SEL_W];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (rd_addr == waddr)) begin
              rd_val = wdata;
            end else begin
              rd_val = mem_q[rd_addr];
            end
`else
            rd_val = mem_q[rd_addr];
`endif
            // The zero register wins even over a forwarded write
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
              rdata_d[i*WIDTH +: WIDTH] = '0;
            end else begin
              rdata_d[i*WIDTH +: WIDTH] = rd_val;
            end
          end
        end
        default: begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      endcase
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage array; contents survive reset and are zeroed by the clear sequence
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport; a ZERO_REG=0 instance shares all stimulus.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata, rdata_z;
  logic        ready, ready_z;

  int tests  = 0;
  int failed = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_multiport #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .ready(ready)
  );

  regfile_multiport #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_z), .ready(ready_z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0; raddr = 10'd0;

    // Reset held for three cycles
    repeat (3) tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata0", rdata[31:0], 32'h0);
    check("rst_rdata1", rdata[63:32], 32'h0);

    // Partial clear, then reset again mid-clear
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check("clr1_ready", {31'd0, ready}, 32'd0);
    end
    rst_n = 1'b0;
    tick();
    check("reclr_ready", {31'd0, ready}, 32'd0);
    check("reclr_rdata", rdata[31:0], 32'h0);

    // Full clear with a write attempt that must be ignored
    rst_n = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF; raddr = {5'd3, 5'd3};
    for (int c = 1; c <= 32; c++) begin
      tick();
      check("clr_ready", {31'd0, ready}, (c == 32) ? 32'd1 : 32'd0);
      check("clr_rdata0", rdata[31:0], 32'h0);
      check("clr_rdata1", rdata[63:32], 32'h0);
    end
    we = 1'b0;
    check("clr_ready_z", {31'd0, ready_z}, 32'd1);

    // Every entry reads zero after clear
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      tick();
      check("zero_p0", rdata[31:0], 32'h0);
      check("zero_p1", rdata[63:32], 32'h0);
      check("zero_z_p0", rdata_z[31:0], 32'h0);
    end

    // Basic write then read on both ports
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr = 10'd0;
    tick();
    we = 1'b0; raddr = {5'd5, 5'd5};
    tick();
    check("wr5_p0", rdata[31:0], 32'hDEAD_BEEF);
    check("wr5_p1", rdata[63:32], 32'hDEAD_BEEF);
    check("wr5_z_p0", rdata_z[31:0], 32'hDEAD_BEEF);

    // Write to entry zero
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678;
    tick();
    we = 1'b0; raddr = {5'd0, 5'd0};
    tick();
    check("r0_zero_p0", rdata[31:0], 32'h0);
    check("r0_zero_p1", rdata[63:32], 32'h0);
    check("r0_plain_p0", rdata_z[31:0], 32'h1234_5678);
    check("r0_plain_p1", rdata_z[63:32], 32'h1234_5678);

    // Read during write to the same address
    we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111;
    tick();
    waddr = 5'd7; wdata = 32'h2222_2222; raddr = {5'd5, 5'd7};
    tick();
    check("rdw_p0", rdata[31:0], BYP ? 32'h2222_2222 : 32'h1111_1111);
    check("rdw_p1", rdata[63:32], 32'hDEAD_BEEF);
    we = 1'b0;
    tick();
    check("rdw_next", rdata[31:0], 32'h2222_2222);

    // Same-edge write and read of entry zero
    we = 1'b1; waddr = 5'd0; wdata = 32'hAAAA_5555; raddr = {5'd7, 5'd0};
    tick();
    we = 1'b0;
    check("byp_r0", rdata[31:0], 32'h0);
    check("byp_r0_plain", rdata_z[31:0], BYP ? 32'hAAAA_5555 : 32'h1234_5678);
    check("byp_r7", rdata[63:32], 32'h2222_2222);

    // Reset while ready returns to clear and re-zeroes the array
    raddr = {5'd7, 5'd5};
    rst_n = 1'b0;
    tick();
    check("rrdy_ready", {31'd0, ready}, 32'd0);
    check("rrdy_rdata", rdata[31:0], 32'h0);
    rst_n = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      check("rrdy_clr_ready", {31'd0, ready}, (c == 32) ? 32'd1 : 32'd0);
    end
    tick();
    check("rrdy_r5", rdata[31:0], 32'h0);
    check("rrdy_r7", rdata[63:32], 32'h0);
    check("rrdy_z_r5", rdata_z[31:0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
